// File: rtl/uart_msg_sender_if.sv
// Handshake bundle between uart_msg_sender, its requester and uart_tx.
// slave is the formatter's view; master is the driving side (requester + transmitter).
interface uart_msg_sender_if;
    logic        i_send;
    logic [23:0] i_data;
    logic        i_tx_busy;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic        o_busy;
    logic        o_done;

    modport slave (
        input  i_send, i_data, i_tx_busy, i_tx_done,
        output o_tx_start, o_tx_data, o_busy, o_done
    );

    modport master (
        output i_send, i_data, i_tx_busy, i_tx_done,
        input  o_tx_start, o_tx_data, o_busy, o_done
    );
endinterface

// File: rtl/uart_msg_sender.sv
// Formats a BCD HH:MM:SS snapshot plus end-of-line into bytes for uart_tx.
// Define MSG_PENDING_EN to queue one request that arrives while a frame is in flight.
module uart_msg_sender #(
    parameter logic [7:0] SEP_CHAR = 8'h3A,
    parameter bit         EOL_CRLF = 1'b1
) (
    input logic               clk,
    input logic               rst,
    uart_msg_sender_if.slave  bus
);

    localparam logic [3:0] LastIdx = EOL_CRLF ? 4'd9 : 4'd8;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic        start_q, start_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef MSG_PENDING_EN
    logic        pend_q, pend_d;
    logic [23:0] pend_data_q, pend_data_d;
`endif

    function automatic logic [7:0] digit(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [23:0] s, input logic [3:0] i);
        case (i)
            4'd0:    return digit(s[23:20]);
            4'd1:    return digit(s[19:16]);
            4'd2:    return SEP_CHAR;
            4'd3:    return digit(s[15:12]);
            4'd4:    return digit(s[11:8]);
            4'd5:    return SEP_CHAR;
            4'd6:    return digit(s[7:4]);
            4'd7:    return digit(s[3:0]);
            4'd8:    return EOL_CRLF ? 8'h0D : 8'h0A;
            default: return 8'h0A;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        start_d = 1'b0;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef MSG_PENDING_EN
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        // Requests in DONE are left for IDLE to pick up if still asserted.
        if (bus.i_send && busy_q && (state_q != StDone)) begin
            pend_d      = 1'b1;
            pend_data_d = bus.i_data;
        end
`endif
        case (state_q)
            StIdle: begin
                if (bus.i_send) begin
                    snap_d  = bus.i_data;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!bus.i_tx_busy) begin
                    start_d = 1'b1;
                    data_d  = frame_byte(snap_q, idx_q);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.i_tx_done) begin
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StSend;
                    end
                end
            end
            StDone: begin
`ifdef MSG_PENDING_EN
                if (pend_q) begin
                    pend_d  = 1'b0;
                    snap_d  = pend_data_q;
                    idx_d   = 4'd0;
                    state_d = StSend;
                end else begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
`else
                busy_d  = 1'b0;
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            idx_q       <= 4'd0;
            snap_q      <= 24'h0;
            start_q     <= 1'b0;
            data_q      <= 8'h00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MSG_PENDING_EN
            pend_q      <= 1'b0;
            pend_data_q <= 24'h0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            start_q     <= start_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MSG_PENDING_EN
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
`endif
        end
    end

    assign bus.o_tx_start = start_q;
    assign bus.o_tx_data  = data_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Scoreboard bench: a CRLF and an LF-only sender share the request stimulus, each
// answered by its own uart_tx model; a monitor pops expected bytes/frame ends per start/done.
module tb_uart_msg_sender;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_msg_sender_if ifa ();
    uart_msg_sender_if ifb ();

    uart_msg_sender #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b1)) u_dut_crlf (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    uart_msg_sender #(.SEP_CHAR(8'h3A), .EOL_CRLF(1'b0)) u_dut_lf (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    logic [1:0]  send_v;
    logic [23:0] data;
    logic [1:0]  m_busy, m_done;
    logic        force_busy;
    int          m_cnt [2];
    bit          fixed_lat;

    assign ifa.i_send    = send_v[0];
    assign ifb.i_send    = send_v[1];
    assign ifa.i_data    = data;
    assign ifb.i_data    = data;
    assign ifa.i_tx_busy = m_busy[0] | force_busy;
    assign ifb.i_tx_busy = m_busy[1] | force_busy;
    assign ifa.i_tx_done = m_done[0];
    assign ifb.i_tx_done = m_done[1];

    logic [1:0] st, bsy, dn;
    logic [7:0] txd [2];
    assign st     = {ifb.o_tx_start, ifa.o_tx_start};
    assign bsy    = {ifb.o_busy, ifa.o_busy};
    assign dn     = {ifb.o_done, ifa.o_done};
    assign txd[0] = ifa.o_tx_data;
    assign txd[1] = ifb.o_tx_data;

    int errors = 0;
    int checks = 0;
    int n_start [2];
    int n_done  [2];
    int q0 [$];
    int q1 [$];

    localparam int FrameEnd = 256;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input int k, input int v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic int pop_exp(input int k);
        if (k == 0) return (q0.size() == 0) ? -1 : q0.pop_front();
        return (q1.size() == 0) ? -1 : q1.pop_front();
    endfunction

    // Expected frame: six ASCII digits with ':' after each pair but the last, then EOL.
    function automatic void push_frame(input int k, input logic [23:0] d);
        for (int i = 0; i < 6; i++) begin
            int n = int'(d[23-4*i -: 4]);
            push_exp(k, (n < 10) ? 48 + n : 63);
            if (i == 1 || i == 3) push_exp(k, 58);
        end
        if (k == 0) push_exp(k, 13);
        push_exp(k, 10);
        push_exp(k, FrameEnd);
    endfunction

    task automatic push_both(input logic [23:0] d);
        push_frame(0, d);
        push_frame(1, d);
    endtask

    // uart_tx model plus output monitor, both evaluated 1 time unit after each edge.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (rst && st[k]) begin
                n_start[k]++;
                check($sformatf("dut%0d_byte%0d", k, n_start[k]), int'(txd[k]), pop_exp(k));
            end
            if (rst && dn[k]) begin
                n_done[k]++;
                check($sformatf("dut%0d_frame_end", k), FrameEnd, pop_exp(k));
            end
            m_done[k] = 1'b0;
            if (!rst) begin
                m_busy[k] = 1'b0;
                m_cnt[k]  = 0;
            end else if (st[k]) begin
                m_busy[k] = 1'b1;
                m_cnt[k]  = fixed_lat ? 20 : int'($urandom_range(1, 20));
            end else if (m_busy[k]) begin
                m_cnt[k]--;
                if (m_cnt[k] <= 0) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_send(input logic [23:0] d);
        tick();
        data   = d;
        send_v = 2'b11;
        tick();
        send_v = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (bsy == 2'b00 && m_busy == 2'b00 && !force_busy) ok = 1'b1;
        end
        check({name, "_idle"}, int'(ok), 1);
        check({name, "_q0_drained"}, q0.size(), 0);
        check({name, "_q1_drained"}, q1.size(), 0);
    endtask

    task automatic wait_starts(input int target);
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            if (n_start[0] >= target) ok = 1'b1;
            else tick();
        end
        check("wait_starts", int'(ok), 1);
    endtask

    task automatic check_reset(input string name);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_dut%0d_start", name, k), int'(st[k]), 0);
            check($sformatf("%s_dut%0d_data", name, k), int'(txd[k]), 0);
            check($sformatf("%s_dut%0d_busy", name, k), int'(bsy[k]), 0);
            check($sformatf("%s_dut%0d_done", name, k), int'(dn[k]), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s, base_d0, base_d1;
        logic [23:0] rd;
        bit ok;

        rst        = 1'b0;
        send_v     = 2'b00;
        data       = 24'h0;
        force_busy = 1'b0;
        fixed_lat  = 1'b1;
        m_busy     = 2'b00;
        m_done     = 2'b00;
        m_cnt[0]   = 0;
        m_cnt[1]   = 0;
        n_start[0] = 0;
        n_start[1] = 0;
        n_done[0]  = 0;
        n_done[1]  = 0;

        repeat (3) tick();
        check_reset("reset");
        rst = 1'b1;
        tick();

        // Basic frame with accept-to-start latency
        push_both(24'h123456);
        data   = 24'h123456;
        send_v = 2'b11;
        tick();
        send_v = 2'b00;
        check("accept_busy", int'(bsy), 3);
        check("accept_no_start", int'(st), 0);
        tick();
        check("first_start_t2", int'(st), 3);
        wait_idle("frame_123456");
        check("done_count_a", n_done[0], 1);
        check("done_count_b", n_done[1], 1);
        check("start_count_a", n_start[0], 10);
        check("start_count_b", n_start[1], 9);

        // Invalid BCD nibbles render as '?'
        fixed_lat = 1'b0;
        push_both(24'h09A0F5);
        pulse_send(24'h09A0F5);
        wait_idle("frame_09a0f5");

        for (int r = 0; r < 6; r++) begin
            rd = 24'($urandom);
            push_both(rd);
            pulse_send(rd);
            wait_idle("frame_random");
        end

        // Back-pressure: no start while the transmitter is busy
        fixed_lat  = 1'b1;
        force_busy = 1'b1;
        base_s     = n_start[0];
        push_both(24'h235959);
        pulse_send(24'h235959);
        repeat (50) tick();
        check("bp_no_start", n_start[0] - base_s, 0);
        check("bp_busy_held", int'(bsy), 3);
        force_busy = 1'b0;
        tick();
        check("bp_start_after_release", int'(st), 3);
        wait_idle("frame_backpressure");

        // Snapshot is frozen once accepted
        base_s = n_start[0];
        push_both(24'h123456);
        pulse_send(24'h123456);
        wait_starts(base_s + 2);
        data = 24'h000000;
        wait_idle("frame_snapshot");

        // Second request mid-frame
        base_s  = n_start[0];
        base_d0 = n_done[0];
        push_both(24'h123456);
        pulse_send(24'h123456);
        wait_starts(base_s + 4);
        data   = 24'h654321;
        send_v = 2'b11;
        tick();
        send_v = 2'b00;
`ifdef MSG_PENDING_EN
        push_both(24'h654321);
        wait_idle("frame_midsend");
        check("midsend_done_count", n_done[0] - base_d0, 2);
        check("midsend_start_count", n_start[0] - base_s, 20);
`else
        wait_idle("frame_midsend");
        check("midsend_done_count", n_done[0] - base_d0, 1);
        check("midsend_start_count", n_start[0] - base_s, 10);
`endif

        // Held request gives back-to-back frames; each side drops it after its 2nd done
        base_d0 = n_done[0];
        base_d1 = n_done[1];
        push_both(24'h101010);
        push_both(24'h101010);
`ifdef MSG_PENDING_EN
        push_both(24'h101010);
`endif
        tick();
        data   = 24'h101010;
        send_v = 2'b11;
        ok     = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            tick();
            if (n_done[0] - base_d0 >= 2) send_v[0] = 1'b0;
            if (n_done[1] - base_d1 >= 2) send_v[1] = 1'b0;
            if (send_v == 2'b00) ok = 1'b1;
        end
        check("held_two_frames", int'(ok), 1);
        send_v = 2'b00;
        wait_idle("frame_held");

        // Reset after the 3rd start abandons the frame
        base_s = n_start[0];
        push_both(24'h111111);
        pulse_send(24'h111111);
        wait_starts(base_s + 3);
        rst = 1'b0;
        #1;
        check_reset("midreset");
        q0.delete();
        q1.delete();
        repeat (5) tick();
        base_s = n_start[0];
        rst    = 1'b1;
        repeat (30) tick();
        check("no_start_after_reset", n_start[0] - base_s, 0);
        push_both(24'h224466);
        pulse_send(24'h224466);
        wait_idle("frame_after_reset");
        check("restart_full_frame", n_start[0] - base_s, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
